// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  // One captured request; valid doubles as the pending flag.
  typedef struct packed {
    logic                 valid;
    logic                 instr;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
  } mem_req_type;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } arb_state_type;

  typedef enum logic {
    GrantI = 1'b0,
    GrantD = 1'b1
  } grant_type;

  // Round-robin tie break: the master that did not go last wins.
  function automatic grant_type other_grant(input grant_type g);
    return (g == GrantI) ? GrantD : GrantI;
  endfunction

endpackage

// File: rtl/mem_arbiter_req.sv
// Pending-request register for one master. A new request captured in the
// same cycle the current one completes takes priority over the clear.
module mem_arbiter_req
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  mem_req_type req_i,
  input  logic        clear_i,
  output mem_req_type req_o
);

  mem_req_type req_d, req_q;

  // Next-state: capture when free or completing, otherwise clear on completion.
  always_comb begin
    req_d = req_q;
    if (capture_i && (!req_q.valid || clear_i)) begin
      req_d       = req_i;
      req_d.valid = 1'b1;
    end else if (clear_i) begin
      req_d.valid = 1'b0;
    end
  end

  // Request register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req_o = req_q;

  // A master must not issue a second request while its first is outstanding.
  pend_overrun_a : assert property (@(posedge clk) disable iff (rst)
    !(capture_i && req_q.valid && !clear_i));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slave memory port between the CPU
// instruction and data ports, one transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned addr_width = AddrWidth,
  parameter int unsigned data_width = DataWidth
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    imemory_valid,
  input  logic                    imemory_instr,
  input  logic [addr_width-1:0]   imemory_addr,
  input  logic [data_width-1:0]   imemory_wdata,
  input  logic [data_width/8-1:0] imemory_wstrb,
  output logic [data_width-1:0]   imemory_rdata,
  output logic                    imemory_ready,

  input  logic                    dmemory_valid,
  input  logic                    dmemory_instr,
  input  logic [addr_width-1:0]   dmemory_addr,
  input  logic [data_width-1:0]   dmemory_wdata,
  input  logic [data_width/8-1:0] dmemory_wstrb,
  output logic [data_width-1:0]   dmemory_rdata,
  output logic                    dmemory_ready,

  output logic                    mem_valid,
  output logic                    mem_instr,
  output logic [addr_width-1:0]   mem_addr,
  output logic [data_width-1:0]   mem_wdata,
  output logic [data_width/8-1:0] mem_wstrb,
  input  logic [data_width-1:0]   mem_rdata,
  input  logic                    mem_ready
);

  mem_req_type   ireq_in, dreq_in, ireq, dreq, sel;
  arb_state_type state_d, state_q;
  grant_type     last_grant_d, last_grant_q, grant;
  logic          grant_en, clear_imem, clear_dmem;

  assign ireq_in = '{valid: imemory_valid, instr: imemory_instr, addr: imemory_addr,
                     wdata: imemory_wdata, wstrb: imemory_wstrb};
  assign dreq_in = '{valid: dmemory_valid, instr: dmemory_instr, addr: dmemory_addr,
                     wdata: dmemory_wdata, wstrb: dmemory_wstrb};

  mem_arbiter_req u_ireq (
    .clk       (clk),
    .rst       (rst),
    .capture_i (imemory_valid),
    .req_i     (ireq_in),
    .clear_i   (clear_imem),
    .req_o     (ireq)
  );

  mem_arbiter_req u_dreq (
    .clk       (clk),
    .rst       (rst),
    .capture_i (dmemory_valid),
    .req_i     (dreq_in),
    .clear_i   (clear_dmem),
    .req_o     (dreq)
  );

  // Arbitration, slave request fields and response routing.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant         = GrantI;
    grant_en      = 1'b0;
    sel           = '0;
    clear_imem    = 1'b0;
    clear_dmem    = 1'b0;
    mem_valid     = 1'b0;
    imemory_ready = 1'b0;
    imemory_rdata = '0;
    dmemory_ready = 1'b0;
    dmemory_rdata = '0;

    unique case (state_q)
      StIdle: begin
        // mem_ready is ignored here so a late response cannot leak to a master.
        if (ireq.valid && dreq.valid) begin
          grant_en = 1'b1;
          grant    = other_grant(last_grant_q);
        end else if (ireq.valid) begin
          grant_en = 1'b1;
          grant    = GrantI;
        end else if (dreq.valid) begin
          grant_en = 1'b1;
          grant    = GrantD;
        end
        if (grant_en) begin
          mem_valid = 1'b1;
          sel       = (grant == GrantD) ? dreq : ireq;
          state_d   = (grant == GrantD) ? StBusyD : StBusyI;
        end
      end
      StBusyI: begin
        sel = ireq;
        if (mem_ready) begin
          imemory_ready = 1'b1;
          imemory_rdata = mem_rdata;
          clear_imem    = 1'b1;
          last_grant_d  = GrantI;
          state_d       = StIdle;
        end
      end
      StBusyD: begin
        sel = dreq;
        if (mem_ready) begin
          dmemory_ready = 1'b1;
          dmemory_rdata = mem_rdata;
          clear_dmem    = 1'b1;
          last_grant_d  = GrantD;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    mem_instr = sel.instr;
    mem_addr  = sel.addr;
    mem_wdata = sel.wdata;
    mem_wstrb = sel.wstrb;
  end

  // State and round-robin history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemory_valid, imemory_instr, imemory_ready;
  logic [31:0] imemory_addr, imemory_wdata, imemory_rdata;
  logic [3:0]  imemory_wstrb;
  logic        dmemory_valid, dmemory_instr, dmemory_ready;
  logic [31:0] dmemory_addr, dmemory_wdata, dmemory_rdata;
  logic [3:0]  dmemory_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t        iss_q[$];
  logic [31:0] ri_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .imemory_valid (imemory_valid),
    .imemory_instr (imemory_instr),
    .imemory_addr  (imemory_addr),
    .imemory_wdata (imemory_wdata),
    .imemory_wstrb (imemory_wstrb),
    .imemory_rdata (imemory_rdata),
    .imemory_ready (imemory_ready),
    .dmemory_valid (dmemory_valid),
    .dmemory_instr (dmemory_instr),
    .dmemory_addr  (dmemory_addr),
    .dmemory_wdata (dmemory_wdata),
    .dmemory_wstrb (dmemory_wstrb),
    .dmemory_rdata (dmemory_rdata),
    .dmemory_ready (dmemory_ready),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_iss(input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_t e;
    e.instr = instr;
    e.addr  = addr;
    e.wdata = wdata;
    e.wstrb = wstrb;
    iss_q.push_back(e);
  endtask

  task automatic req_i(input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    imemory_valid = 1'b1;
    imemory_instr = instr;
    imemory_addr  = addr;
    imemory_wdata = wdata;
    imemory_wstrb = wstrb;
  endtask

  task automatic req_d(input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    dmemory_valid = 1'b1;
    dmemory_instr = instr;
    dmemory_addr  = addr;
    dmemory_wdata = wdata;
    dmemory_wstrb = wstrb;
  endtask

  // Bounded wait for the next slave request.
  task automatic wait_issue(input string name);
    int n = 0;
    while (!mem_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_issued"}, 32'(mem_valid), 32'd1);
  endtask

  // Called in the issue cycle; returns in the cycle after the response.
  task automatic serve(input int lat, input logic [31:0] rd);
    repeat (lat) tick();
    mem_ready = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
  endtask

  // Monitor: compare every slave request and every master response against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_valid) begin
        if (iss_q.size() == 0) begin
          chk("unexpected_issue", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = iss_q.pop_front();
          chk("issue_addr", mem_addr, e.addr);
          chk("issue_instr", 32'(mem_instr), 32'(e.instr));
          chk("issue_wdata", mem_wdata, e.wdata);
          chk("issue_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        end
      end
      if (imemory_ready) begin
        if (ri_q.size() == 0) chk("unexpected_i_ready", imemory_rdata, 32'hFFFF_FFFF);
        else chk("i_rdata", imemory_rdata, ri_q.pop_front());
      end else if (mem_ready) begin
        chk("i_rdata_idle", imemory_rdata, 32'd0);
      end
      if (dmemory_ready) begin
        if (rd_q.size() == 0) chk("unexpected_d_ready", dmemory_rdata, 32'hFFFF_FFFF);
        else chk("d_rdata", dmemory_rdata, rd_q.pop_front());
      end else if (mem_ready) begin
        chk("d_rdata_idle", dmemory_rdata, 32'd0);
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({name, "_mem_addr"}, mem_addr, 32'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({name, "_i_ready"}, 32'(imemory_ready), 32'd0);
    chk({name, "_d_ready"}, 32'(dmemory_ready), 32'd0);
    chk({name, "_i_rdata"}, imemory_rdata, 32'd0);
    chk({name, "_d_rdata"}, dmemory_rdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    imemory_valid = 0; imemory_instr = 0; imemory_addr = 0; imemory_wdata = 0; imemory_wstrb = 0;
    dmemory_valid = 0; dmemory_instr = 0; dmemory_addr = 0; dmemory_wdata = 0; dmemory_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    chk_all_zero("post_release");

    // I-only, slave answers 2 cycles after mem_valid.
    tick();
    req_i(1'b1, 32'h100, 32'h0, 4'h0);
    push_iss(1'b1, 32'h100, 32'h0, 4'h0);
    ri_q.push_back(32'hDEAD_BEEF);
    tick();
    imemory_valid = 1'b0;
    chk("t1_issue_latency", 32'(mem_valid), 32'd1);
    tick();
    chk("t1_busy_no_valid", 32'(mem_valid), 32'd0);
    chk("t1_busy_addr_held", mem_addr, 32'h100);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_i_ready", 32'(imemory_ready), 32'd1);
    chk("t1_i_rdata", imemory_rdata, 32'hDEAD_BEEF);
    chk("t1_d_ready", 32'(dmemory_ready), 32'd0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk("t1_done_i_ready", 32'(imemory_ready), 32'd0);
    chk("t1_done_mem_addr", mem_addr, 32'd0);

    // Tie after reset: D first, then I one cycle after D's ready.
    tick();
    req_i(1'b1, 32'h10, 32'h0, 4'h0);
    req_d(1'b0, 32'h20, 32'hCAFE_0001, 4'hF);
    push_iss(1'b0, 32'h20, 32'hCAFE_0001, 4'hF);
    push_iss(1'b1, 32'h10, 32'h0, 4'h0);
    rd_q.push_back(32'h1111_1111);
    ri_q.push_back(32'h2222_2222);
    tick();
    imemory_valid = 1'b0;
    dmemory_valid = 1'b0;
    chk("t2_tie_valid", 32'(mem_valid), 32'd1);
    chk("t2_tie_d_first", mem_addr, 32'h20);
    serve(1, 32'h1111_1111);
    chk("t2_i_next_valid", 32'(mem_valid), 32'd1);
    chk("t2_i_next_addr", mem_addr, 32'h10);
    serve(1, 32'h2222_2222);

    // Lone D so that D went last; the next tie must go to I.
    tick();
    req_d(1'b0, 32'h24, 32'h0, 4'h0);
    push_iss(1'b0, 32'h24, 32'h0, 4'h0);
    rd_q.push_back(32'h3333_3333);
    tick();
    dmemory_valid = 1'b0;
    wait_issue("t2_lone_d");
    serve(1, 32'h3333_3333);
    tick();
    req_i(1'b1, 32'h14, 32'h0, 4'h0);
    req_d(1'b0, 32'h28, 32'h0, 4'h1);
    push_iss(1'b1, 32'h14, 32'h0, 4'h0);
    push_iss(1'b0, 32'h28, 32'h0, 4'h1);
    ri_q.push_back(32'h4444_4444);
    rd_q.push_back(32'h5555_5555);
    tick();
    imemory_valid = 1'b0;
    dmemory_valid = 1'b0;
    chk("t2b_tie_i_first", mem_addr, 32'h14);
    serve(1, 32'h4444_4444);
    chk("t2b_d_next", mem_addr, 32'h28);
    serve(1, 32'h5555_5555);

    // Back-to-back D with I arriving during BUSY_D: I goes between the two D requests.
    tick();
    req_d(1'b0, 32'h30, 32'h1234_5678, 4'h3);
    push_iss(1'b0, 32'h30, 32'h1234_5678, 4'h3);
    rd_q.push_back(32'h6666_6666);
    tick();
    dmemory_valid = 1'b0;
    chk("t3_d1_issued", 32'(mem_valid), 32'd1);
    tick();
    req_i(1'b1, 32'h40, 32'h0, 4'h0);
    push_iss(1'b1, 32'h40, 32'h0, 4'h0);
    ri_q.push_back(32'h7777_7777);
    tick();
    imemory_valid = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h6666_6666;
    req_d(1'b0, 32'h34, 32'h0, 4'hF);
    push_iss(1'b0, 32'h34, 32'h0, 4'hF);
    rd_q.push_back(32'h8888_8888);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    dmemory_valid = 1'b0;
    #1;
    chk("t3_i_between", mem_addr, 32'h40);
    serve(1, 32'h7777_7777);
    chk("t3_d2_after_i", mem_addr, 32'h34);
    serve(1, 32'h8888_8888);

    // Set-over-clear on the data port.
    tick();
    req_d(1'b0, 32'h50, 32'h0, 4'h1);
    push_iss(1'b0, 32'h50, 32'h0, 4'h1);
    rd_q.push_back(32'h9999_9999);
    tick();
    dmemory_valid = 1'b0;
    wait_issue("t4_first");
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h9999_9999;
    req_d(1'b0, 32'h44, 32'hA5A5_A5A5, 4'hF);
    push_iss(1'b0, 32'h44, 32'hA5A5_A5A5, 4'hF);
    rd_q.push_back(32'hAAAA_0000);
    #1;
    chk("t4_d_ready", 32'(dmemory_ready), 32'd1);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    dmemory_valid = 1'b0;
    #1;
    chk("t4_recapture_valid", 32'(mem_valid), 32'd1);
    chk("t4_recapture_addr", mem_addr, 32'h44);
    serve(1, 32'hAAAA_0000);

    // Reset while BUSY_I, then a late mem_ready.
    tick();
    req_i(1'b1, 32'h60, 32'h0, 4'h0);
    push_iss(1'b1, 32'h60, 32'h0, 4'h0);
    tick();
    imemory_valid = 1'b0;
    chk("t5_issued", 32'(mem_valid), 32'd1);
    tick();
    chk("t5_busy_addr", mem_addr, 32'h60);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("t5_async_reset");
    tick();
    rst = 1'b0;
    chk_all_zero("t5_after_release");
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk_all_zero("t5_late_ready");
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    req_i(1'b1, 32'h70, 32'h0, 4'h0);
    push_iss(1'b1, 32'h70, 32'h0, 4'h0);
    ri_q.push_back(32'hBBBB_BBBB);
    tick();
    imemory_valid = 1'b0;
    wait_issue("t5_recover");
    serve(2, 32'hBBBB_BBBB);

    // Stray mem_ready in IDLE with nothing pending.
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    #1;
    chk_all_zero("t6_stray");
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk_all_zero("t6_still_idle");

    repeat (3) tick();
    chk("end_iss_q_empty", iss_q.size(), 32'd0);
    chk("end_ri_q_empty", ri_q.size(), 32'd0);
    chk("end_rd_q_empty", rd_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
